urv_dmem_bridge: RTL and testbench

Data-memory responder for the uRV execute stage. Accepts the single-cycle load/store strobes the core drives (address, store data, byte select) and performs each access as a pipelined Wishbone master cycle. Returns load data, completion pulses, bus errors and timeouts to the core. Sits between the CPU core and the system interconnect; one outstanding access at a time.

---
 rtl/urv_dmem_bridge_if.sv | 30 +++
 rtl/urv_dmem_bridge.sv | 168 ++++++++++++++++
 tb/tb_urv_dmem_bridge.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/urv_dmem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : urv_dmem_bridge_if
// Description : Pipelined Wishbone bus bundle between the uRV data-memory
//               bridge (master) and the system interconnect (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface urv_dmem_bridge_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_stall_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
    );
endinterface
`default_nettype wire

// File: rtl/urv_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : urv_dmem_bridge
// Description : uRV execute-stage data-memory responder. Turns single-cycle
//               load/store strobes into pipelined Wishbone master cycles, one
//               outstanding access at a time, with bus-error and timeout
//               reporting back to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module urv_dmem_bridge #(
    parameter int unsigned g_timeout_cycles = 255,
    parameter int unsigned g_posted_stores  = 1
) (
    input  wire logic        clk_i,
    input  wire logic        rst_n_i,

    input  wire logic [31:0] dm_addr_i,
    input  wire logic [31:0] dm_data_s_i,
    input  wire logic [3:0]  dm_data_select_i,
    input  wire logic        dm_load_i,
    input  wire logic        dm_store_i,
    output logic             dm_ready_o,
    output logic [31:0]      dm_data_l_o,
    output logic             dm_load_done_o,
    output logic             dm_store_done_o,
    output logic             dm_bus_error_o,
    output logic [31:0]      dm_err_addr_o,

    urv_dmem_bridge_if.master wb
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] c_timeout = g_timeout_cycles[15:0];
    localparam bit          c_posted  = (g_posted_stores != 0);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    logic [31:0] wb_adr_q;
    logic [31:0] wb_dat_q;
    logic [3:0]  wb_sel_q;
    logic        wb_we_q;
    logic        wb_cyc_q;
    logic        wb_stb_q;

    logic [31:0] data_l_q;
    logic        load_done_q;
    logic        store_done_q;
    logic        bus_error_q;
    logic [31:0] err_addr_q;

    logic        busy;
    logic        resp_ok;
    logic        ack_seen;
    logic        err_seen;
    logic        timeout;
    logic        finish;
    logic        fail;
    logic        is_store_req;

    // Completion decode: a response counts in WAIT, or in REQ once the
    // strobe has actually been taken (stall low).
    always_comb begin
        busy         = (state_q == ST_REQ) || (state_q == ST_WAIT);
        resp_ok      = (state_q == ST_WAIT) || ((state_q == ST_REQ) && !wb.wb_stall_i);
        cnt_d        = cnt_q + 16'd1;
        ack_seen     = resp_ok && wb.wb_ack_i;
        err_seen     = resp_ok && wb.wb_err_i;
        // cnt_q is 0 in the first bus cycle, so the abort fires after
        // exactly g_timeout_cycles cycles spent in REQ/WAIT.
        timeout      = busy && (cnt_d == c_timeout);
        finish       = ack_seen || err_seen || timeout;
        fail         = err_seen || (timeout && !ack_seen);
        is_store_req = dm_store_i && !dm_load_i;
    end

    // Bridge FSM with all bus and core-side outputs registered.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 16'd0;
            wb_adr_q     <= 32'd0;
            wb_dat_q     <= 32'd0;
            wb_sel_q     <= 4'd0;
            wb_we_q      <= 1'b0;
            wb_cyc_q     <= 1'b0;
            wb_stb_q     <= 1'b0;
            data_l_q     <= 32'd0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_error_q  <= 1'b0;
            err_addr_q   <= 32'd0;
        end else begin
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            bus_error_q  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (dm_load_i || dm_store_i) begin
                        wb_adr_q <= dm_addr_i;
                        wb_dat_q <= dm_data_s_i;
                        wb_we_q  <= is_store_req;
                        // The core extracts bytes itself, so loads fetch the full word.
                        wb_sel_q <= is_store_req ? dm_data_select_i : 4'hF;
                        wb_cyc_q <= 1'b1;
                        wb_stb_q <= 1'b1;
                        cnt_q    <= 16'd0;
                        state_q  <= ST_REQ;
                        if (c_posted && is_store_req) begin
                            store_done_q <= 1'b1;
                        end
                    end
                end

                ST_REQ, ST_WAIT: begin
                    cnt_q <= cnt_d;
                    if (finish) begin
                        wb_cyc_q <= 1'b0;
                        wb_stb_q <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (!wb_we_q) begin
                            load_done_q <= 1'b1;
                            data_l_q    <= fail ? 32'd0 : wb.wb_dat_i;
                        end else if (!c_posted) begin
                            store_done_q <= 1'b1;
                        end
                        if (fail) begin
                            bus_error_q <= 1'b1;
                            err_addr_q  <= wb_adr_q;
                        end
                    end else if ((state_q == ST_REQ) && !wb.wb_stall_i) begin
                        wb_stb_q <= 1'b0;
                        state_q  <= ST_WAIT;
                    end
                end

                default: begin
                    wb_cyc_q <= 1'b0;
                    wb_stb_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign dm_ready_o      = (state_q == ST_IDLE);
    assign dm_data_l_o     = data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;
    assign dm_bus_error_o  = bus_error_q;
    assign dm_err_addr_o   = err_addr_q;

    assign wb.wb_adr_o = wb_adr_q;
    assign wb.wb_dat_o = wb_dat_q;
    assign wb.wb_sel_o = wb_sel_q;
    assign wb.wb_we_o  = wb_we_q;
    assign wb.wb_cyc_o = wb_cyc_q;
    assign wb.wb_stb_o = wb_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_urv_dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_urv_dmem_bridge
// Description : Self-checking bench for urv_dmem_bridge. A posted-store
//               instance is scoreboarded; a non-posted instance runs in
//               lockstep on the same stimulus for store-completion timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_urv_dmem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] addr, sdat, rdat;
    logic [3:0]  sel;
    logic        ld, st, ack, err, stall;

    logic        p_ready, p_ld, p_st, p_er;
    logic [31:0] p_data_l, p_eaddr;
    logic        n_ready, n_ld, n_st, n_er;
    logic [31:0] n_data_l, n_eaddr;

    urv_dmem_bridge_if bus_p ();
    urv_dmem_bridge_if bus_n ();

    assign bus_p.wb_dat_i   = rdat;
    assign bus_p.wb_ack_i   = ack;
    assign bus_p.wb_err_i   = err;
    assign bus_p.wb_stall_i = stall;
    assign bus_n.wb_dat_i   = rdat;
    assign bus_n.wb_ack_i   = ack;
    assign bus_n.wb_err_i   = err;
    assign bus_n.wb_stall_i = stall;

    urv_dmem_bridge #(.g_timeout_cycles(8), .g_posted_stores(1)) dut_p (
        .clk_i(clk), .rst_n_i(rst_n),
        .dm_addr_i(addr), .dm_data_s_i(sdat), .dm_data_select_i(sel),
        .dm_load_i(ld), .dm_store_i(st), .dm_ready_o(p_ready),
        .dm_data_l_o(p_data_l), .dm_load_done_o(p_ld), .dm_store_done_o(p_st),
        .dm_bus_error_o(p_er), .dm_err_addr_o(p_eaddr), .wb(bus_p.master)
    );

    urv_dmem_bridge #(.g_timeout_cycles(8), .g_posted_stores(0)) dut_n (
        .clk_i(clk), .rst_n_i(rst_n),
        .dm_addr_i(addr), .dm_data_s_i(sdat), .dm_data_select_i(sel),
        .dm_load_i(ld), .dm_store_i(st), .dm_ready_o(n_ready),
        .dm_data_l_o(n_data_l), .dm_load_done_o(n_ld), .dm_store_done_o(n_st),
        .dm_bus_error_o(n_er), .dm_err_addr_o(n_eaddr), .wb(bus_n.master)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        bit          ld;
        bit          st;
        bit          er;
        logic [31:0] data;
        logic [31:0] eaddr;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic push(input bit l, input bit s, input bit er,
                        input logic [31:0] d, input logic [31:0] ea, input int at);
        exp_t x;
        x.ld = l; x.st = s; x.er = er; x.data = d; x.eaddr = ea; x.at = at;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor on the posted instance: every completion/error pulse
    // must match the next expected event, including the cycle it lands in.
    always @(negedge clk) begin
        if (p_ld || p_st || p_er) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, p_ld, p_st, p_er}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("mon_load_done",  {31'd0, p_ld}, {31'd0, e.ld});
                chk("mon_store_done", {31'd0, p_st}, {31'd0, e.st});
                chk("mon_bus_error",  {31'd0, p_er}, {31'd0, e.er});
                chk("mon_cycle", cyc_n, e.at);
                if (e.ld) chk("mon_load_data", p_data_l, e.data);
                if (e.er) chk("mon_err_addr", p_eaddr, e.eaddr);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int c0;

    initial begin
        rst_n = 1'b0; addr = '0; sdat = '0; sel = '0; ld = 1'b0; st = 1'b0;
        rdat = '0; ack = 1'b0; err = 1'b0; stall = 1'b0;
        tick(); tick();
        chk("rst_ready",    {31'd0, p_ready}, 32'd1);
        chk("rst_cyc",      {31'd0, bus_p.wb_cyc_o}, 32'd0);
        chk("rst_stb",      {31'd0, bus_p.wb_stb_o}, 32'd0);
        chk("rst_adr",      bus_p.wb_adr_o, 32'd0);
        chk("rst_sel",      {28'd0, bus_p.wb_sel_o}, 32'd0);
        chk("rst_data_l",   p_data_l, 32'd0);
        chk("rst_err_addr", p_eaddr, 32'd0);
        rst_n = 1'b1;
        tick();

        // Load, zero wait states
        c0 = cyc_n; ld = 1'b1; addr = 32'h1000;
        push(1, 0, 0, 32'hDEADBEEF, 32'd0, c0 + 3);
        tick(); ld = 1'b0; addr = '0;
        chk("ld_t1_cyc",   {31'd0, bus_p.wb_cyc_o}, 32'd1);
        chk("ld_t1_stb",   {31'd0, bus_p.wb_stb_o}, 32'd1);
        chk("ld_t1_sel",   {28'd0, bus_p.wb_sel_o}, 32'hF);
        chk("ld_t1_we",    {31'd0, bus_p.wb_we_o}, 32'd0);
        chk("ld_t1_adr",   bus_p.wb_adr_o, 32'h1000);
        chk("ld_t1_ready", {31'd0, p_ready}, 32'd0);
        tick();
        chk("ld_t2_stb", {31'd0, bus_p.wb_stb_o}, 32'd0);
        chk("ld_t2_cyc", {31'd0, bus_p.wb_cyc_o}, 32'd1);
        ack = 1'b1; rdat = 32'hDEADBEEF;
        tick(); ack = 1'b0; rdat = '0;
        chk("ld_t3_ready", {31'd0, p_ready}, 32'd1);
        chk("ld_t3_cyc",   {31'd0, bus_p.wb_cyc_o}, 32'd0);

        // Posted store with three stall cycles
        c0 = cyc_n; st = 1'b1; addr = 32'h2002; sel = 4'b1100; sdat = 32'hABCDABCD; stall = 1'b1;
        push(0, 1, 0, 32'd0, 32'd0, c0 + 1);
        tick(); st = 1'b0;
        chk("st_sel", {28'd0, bus_p.wb_sel_o}, 32'hC);
        chk("st_we",  {31'd0, bus_p.wb_we_o}, 32'd1);
        chk("st_dat", bus_p.wb_dat_o, 32'hABCDABCD);
        chk("st_adr", bus_p.wb_adr_o, 32'h2002);
        chk("np_st_t1_no_done", {31'd0, n_st}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            chk("st_stb_held", {31'd0, bus_p.wb_stb_o}, 32'd1);
            chk("st_ready_low", {31'd0, p_ready}, 32'd0);
            if (k == 4) stall = 1'b0;
            tick();
        end
        chk("st_t5_stb",   {31'd0, bus_p.wb_stb_o}, 32'd0);
        chk("st_t5_ready", {31'd0, p_ready}, 32'd0);
        ack = 1'b1;
        tick(); ack = 1'b0;
        chk("st_t6_ready",   {31'd0, p_ready}, 32'd1);
        chk("np_st_ack_done", {31'd0, n_st}, 32'd1);

        // Bus error on load
        c0 = cyc_n; ld = 1'b1; addr = 32'h3000;
        push(1, 0, 1, 32'd0, 32'h3000, c0 + 3);
        tick(); ld = 1'b0;
        tick(); err = 1'b1; rdat = 32'h55555555;
        tick(); err = 1'b0; rdat = '0;
        chk("lderr_ready", {31'd0, p_ready}, 32'd1);

        // Bus error on posted store: done at T1, error alone at T3
        c0 = cyc_n; st = 1'b1; addr = 32'h5000; sel = 4'hF; sdat = 32'h11223344;
        push(0, 1, 0, 32'd0, 32'd0, c0 + 1);
        push(0, 0, 1, 32'd0, 32'h5000, c0 + 3);
        tick(); st = 1'b0;
        tick(); err = 1'b1;
        tick(); err = 1'b0;
        chk("np_sterr_done",  {31'd0, n_st}, 32'd1);
        chk("np_sterr_error", {31'd0, n_er}, 32'd1);
        chk("np_sterr_addr",  n_eaddr, 32'h5000);

        // Timeout after 8 bus cycles, then a stray ack
        c0 = cyc_n; ld = 1'b1; addr = 32'h4000;
        push(1, 0, 1, 32'd0, 32'h4000, c0 + 9);
        tick(); ld = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("to_cyc_high", {31'd0, bus_p.wb_cyc_o}, 32'd1);
            tick();
        end
        chk("to_t9_cyc",   {31'd0, bus_p.wb_cyc_o}, 32'd0);
        chk("to_t9_ready", {31'd0, p_ready}, 32'd1);
        tick(); tick(); tick();
        ack = 1'b1;
        tick(); ack = 1'b0;
        chk("to_stray_no_done", {31'd0, p_ld}, 32'd0);
        chk("to_stray_no_cyc",  {31'd0, bus_p.wb_cyc_o}, 32'd0);

        // Conflicting strobes, ignored request while busy, back-to-back accept
        c0 = cyc_n; ld = 1'b1; st = 1'b1; addr = 32'h6000; sdat = 32'hFFFF0000; sel = 4'b0011;
        push(1, 0, 0, 32'h12345678, 32'd0, c0 + 3);
        tick(); ld = 1'b0; st = 1'b1; addr = 32'h7000;
        chk("cf_we",  {31'd0, bus_p.wb_we_o}, 32'd0);
        chk("cf_sel", {28'd0, bus_p.wb_sel_o}, 32'hF);
        chk("cf_adr", bus_p.wb_adr_o, 32'h6000);
        tick(); st = 1'b0;
        chk("cf_ignored_adr", bus_p.wb_adr_o, 32'h6000);
        ack = 1'b1; rdat = 32'h12345678;
        tick(); ack = 1'b0; rdat = '0;
        chk("cf_ready", {31'd0, p_ready}, 32'd1);
        chk("np_cf_no_store_done", {31'd0, n_st}, 32'd0);
        c0 = cyc_n; st = 1'b1; addr = 32'h8000; sel = 4'b0001; sdat = 32'h000000AA;
        push(0, 1, 0, 32'd0, 32'd0, c0 + 1);
        tick(); st = 1'b0;
        chk("b2b_cyc", {31'd0, bus_p.wb_cyc_o}, 32'd1);
        chk("b2b_adr", bus_p.wb_adr_o, 32'h8000);
        chk("b2b_we",  {31'd0, bus_p.wb_we_o}, 32'd1);
        chk("b2b_sel", {28'd0, bus_p.wb_sel_o}, 32'h1);
        tick(); ack = 1'b1;
        tick(); ack = 1'b0;
        chk("np_b2b_done", {31'd0, n_st}, 32'd1);

        // Reset during WAIT
        ld = 1'b1; addr = 32'h9000;
        tick(); ld = 1'b0;
        tick();
        chk("mr_wait_cyc", {31'd0, bus_p.wb_cyc_o}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_cyc",      {31'd0, bus_p.wb_cyc_o}, 32'd0);
        chk("mr_stb",      {31'd0, bus_p.wb_stb_o}, 32'd0);
        chk("mr_adr",      bus_p.wb_adr_o, 32'd0);
        chk("mr_sel",      {28'd0, bus_p.wb_sel_o}, 32'd0);
        chk("mr_data_l",   p_data_l, 32'd0);
        chk("mr_err_addr", p_eaddr, 32'd0);
        chk("mr_ready",    {31'd0, p_ready}, 32'd1);
        rst_n = 1'b1;
        tick();
        chk("mr_ready_after", {31'd0, p_ready}, 32'd1);
        tick(); tick(); tick();

        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
